// File: rtl/predict_if.sv
// Bus bundle for the predict block: weight/feature load ports, start request and result.
interface predict_if #(
  parameter int unsigned DW = 16
) ();
  logic                 w_we;
  logic [7:0]           w_addr;
  logic signed [DW-1:0] w_data;
  logic                 x_we;
  logic [3:0]           x_addr;
  logic signed [DW-1:0] x_data;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic signed [DW-1:0] y;

  modport master (
    output w_we, w_addr, w_data, x_we, x_addr, x_data, start,
    input  busy, done, y
  );

  modport slave (
    input  w_we, w_addr, w_data, x_we, x_addr, x_data, start,
    output busy, done, y
  );
endinterface

// File: rtl/predict.sv
// Two-layer fixed-point MLP (15 inputs, 10 ReLU hidden units, 1 linear output).
// A single MAC is time-shared across both layers. Memory entry 170 holds the output bias.
module predict #(
  parameter int unsigned DW   = 16,
  parameter int unsigned FRAC = 8
) (
  input  logic     clk,
  input  logic     rst,
  predict_if.slave bus
);
  localparam int unsigned NIn  = 15;
  localparam int unsigned NHid = 10;
  localparam int unsigned AW   = 2 * DW + 8;

  localparam logic signed [AW-1:0] SatMax = AW'((64'sd1 <<< (DW - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] SatMin = -SatMax - AW'(1);

  typedef enum logic [1:0] {StIdle, StHid, StOut, StDone} state_e;

  state_e               state_q, state_d;
  logic [3:0]           i_q, i_d;  // neuron index in HID, output-weight index in OUT
  logic [3:0]           j_q, j_d;  // input index; 15 is the bias/rescale step
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [DW-1:0] h_q [NHid];
  logic signed [DW-1:0] y_q;
  logic                 done_q;
  logic                 h_we;

  logic signed [DW-1:0] w_mem [171];
  logic signed [DW-1:0] x_mem [NIn];

  logic                   busy;
  logic [7:0]             w_sel_addr;
  logic signed [DW-1:0]   w_sel;
  logic signed [DW-1:0]   opnd;
  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   prod_ext;
  logic signed [AW-1:0]   bias_ext;
  logic signed [DW-1:0]   hid_sat;
  logic signed [DW-1:0]   hid_act;

  // Arithmetic shift (floor) by FRAC, then clamp to the DW-bit signed range.
  function automatic logic signed [DW-1:0] sat_rescale(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] s;
    s = v >>> FRAC;
    if (s > SatMax) begin
      s = SatMax;
    end else if (s < SatMin) begin
      s = SatMin;
    end
    return s[DW-1:0];
  endfunction

  assign busy = (state_q == StHid) || (state_q == StOut);

  // Weight and feature storage: no reset, loads blocked while an inference runs.
  always_ff @(posedge clk) begin
    if (bus.w_we && !busy && (bus.w_addr <= 8'd170)) begin
      w_mem[bus.w_addr] <= bus.w_data;
    end
    if (bus.x_we && !busy && (bus.x_addr <= 4'd14)) begin
      x_mem[bus.x_addr] <= bus.x_data;
    end
  end

  // Operand selection; hidden weights sit at {neuron, input}, output weights at 160+k.
  always_comb begin
    w_sel_addr = (state_q == StOut) ? (8'd160 + {4'd0, i_q}) : {i_q, j_q};
    w_sel      = (w_sel_addr <= 8'd170) ? w_mem[w_sel_addr] : '0;
    opnd       = '0;
    if (state_q == StOut) begin
      if (i_q < 4'(NHid)) begin
        opnd = h_q[i_q];
      end
    end else if (j_q < 4'(NIn)) begin
      opnd = x_mem[j_q];
    end
    prod     = w_sel * opnd;
    prod_ext = AW'(prod);
    bias_ext = AW'(w_sel) <<< FRAC;
    hid_sat  = sat_rescale(acc_q + bias_ext);
    hid_act  = hid_sat[DW-1] ? '0 : hid_sat;
  end

  // Next-state logic: MAC sequencing over both layers.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    h_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StHid;
          i_d     = '0;
          j_d     = '0;
          acc_d   = '0;
        end
      end
      StHid: begin
        if (j_q == 4'd15) begin
          h_we  = 1'b1;
          acc_d = '0;
          j_d   = '0;
          if (i_q == 4'(NHid - 1)) begin
            state_d = StOut;
            i_d     = '0;
          end else begin
            i_d = i_q + 4'd1;
          end
        end else begin
          acc_d = acc_q + prod_ext;
          j_d   = j_q + 4'd1;
        end
      end
      StOut: begin
        if (i_q == 4'(NHid)) begin
          acc_d   = acc_q + bias_ext;
          state_d = StDone;
        end else begin
          acc_d = acc_q + prod_ext;
          i_d   = i_q + 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
      for (int k = 0; k < int'(NHid); k++) begin
        h_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      done_q  <= (state_q == StDone);
      if (h_we) begin
        h_q[i_q] <= hid_act;
      end
      if (state_q == StDone) begin
        y_q <= sat_rescale(acc_q);
      end
    end
  end

  assign bus.busy = busy;
  assign bus.done = done_q;
  assign bus.y    = y_q;
endmodule

// File: tb/tb_predict.sv
// Bench for predict: directed cases plus randomized networks against an arithmetic model.
module tb_predict;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  logic signed [15:0] mw [0:170];
  logic signed [15:0] mx [0:14];

  predict_if #(.DW(16)) bus ();

  predict #(.DW(16), .FRAC(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint ref_sat(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Network evaluated straight from the arithmetic definition.
  function automatic longint ref_y();
    longint acc;
    longint s;
    longint h [10];
    for (int i = 0; i < 10; i++) begin
      acc = longint'(mw[i * 16 + 15]) * 256;
      for (int j = 0; j < 15; j++) acc += longint'(mw[i * 16 + j]) * longint'(mx[j]);
      s    = ref_sat(acc >>> 8);
      h[i] = (s < 0) ? 0 : s;
    end
    acc = longint'(mw[170]) * 256;
    for (int i = 0; i < 10; i++) acc += longint'(mw[160 + i]) * h[i];
    return ref_sat(acc >>> 8);
  endfunction

  task automatic write_w(input int addr, input int data);
    @(negedge clk);
    bus.w_we   = 1'b1;
    bus.w_addr = 8'(addr);
    bus.w_data = 16'(data);
    @(posedge clk);
    #1 bus.w_we = 1'b0;
    if (addr <= 170) mw[addr] = 16'(data);
  endtask

  task automatic write_x(input int addr, input int data);
    @(negedge clk);
    bus.x_we   = 1'b1;
    bus.x_addr = 4'(addr);
    bus.x_data = 16'(data);
    @(posedge clk);
    #1 bus.x_we = 1'b0;
    if (addr <= 14) mx[addr] = 16'(data);
  endtask

  task automatic clear_all();
    for (int a = 0; a <= 170; a++) write_w(a, 0);
    for (int a = 0; a < 15; a++) write_x(a, 0);
  endtask

  task automatic run(input string tag, input longint exp_y, input bit disturb);
    int lat;
    int busy_cnt;
    int extra;
    bit seen;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    busy_cnt = bus.busy ? 1 : 0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 400) begin
      @(posedge clk);
      #1 lat++;
      if (disturb) begin
        if (lat >= 20 && lat <= 22) begin
          bus.start  = 1'b1;
          bus.w_we   = 1'b1;
          bus.w_addr = 8'd0;
          bus.w_data = 16'h7000;
          bus.x_we   = 1'b1;
          bus.x_addr = 4'd0;
          bus.x_data = 16'h0000;
        end else begin
          bus.start = 1'b0;
          bus.w_we  = 1'b0;
          bus.x_we  = 1'b0;
        end
      end
      if (bus.done) seen = 1'b1;
      else if (bus.busy) busy_cnt++;
    end
    check({tag, ".latency"}, lat, 172);
    check({tag, ".busy_cycles"}, busy_cnt, 171);
    check({tag, ".busy_at_done"}, longint'(bus.busy), 0);
    check({tag, ".y"}, longint'(bus.y), exp_y);
    @(posedge clk);
    #1 check({tag, ".done_width"}, longint'(bus.done), 0);
    if (disturb) begin
      extra = 0;
      for (int c = 0; c < 200; c++) begin
        @(posedge clk);
        #1 if (bus.done) extra++;
      end
      check({tag, ".extra_done"}, extra, 0);
    end
  endtask

  task automatic abort_run(input string tag);
    int dn;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (50) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check({tag, ".busy"}, longint'(bus.busy), 0);
    check({tag, ".done"}, longint'(bus.done), 0);
    check({tag, ".y"}, longint'(bus.y), 0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1 if (bus.done || bus.busy) dn++;
    end
    check({tag, ".no_done"}, dn, 0);
  endtask

  function automatic int rand_val();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 65535)) - 32768;
    return int'($urandom_range(0, 1023)) - 512;
  endfunction

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.w_we   = 1'b0;
    bus.w_addr = '0;
    bus.w_data = '0;
    bus.x_we   = 1'b0;
    bus.x_addr = '0;
    bus.x_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", longint'(bus.busy), 0);
    check("reset.done", longint'(bus.done), 0);
    check("reset.y", longint'(bus.y), 0);
    @(negedge clk);
    rst = 1'b0;

    // Output bias only.
    clear_all();
    write_w(170, 16'h0100);
    run("bias_only", 256, 1'b0);

    // Single path, positive hidden activation.
    clear_all();
    write_x(0, 16'h0200);
    write_w(0, 16'h0100);
    write_w(160, 16'h0080);
    run("single_path", 256, 1'b0);

    // Negative hidden pre-activation is clipped by ReLU.
    write_w(0, 16'hFF00);
    write_w(160, 16'h0100);
    run("relu_clip", 0, 1'b0);

    // Hidden unit saturates at the positive rail.
    clear_all();
    for (int j = 0; j < 15; j++) begin
      write_x(j, 16'h7F00);
      write_w(j, 16'h0100);
    end
    write_w(160, 16'h0100);
    run("hid_sat", 32767, 1'b0);

    // Reset mid-run aborts; memories survive.
    clear_all();
    write_x(0, 16'h0200);
    write_w(0, 16'h0100);
    write_w(160, 16'h0080);
    run("pre_abort", 256, 1'b0);
    abort_run("abort");
    run("post_abort", 256, 1'b0);

    // Start and writes while busy are ignored.
    run("disturb", 256, 1'b1);
    run("after_disturb", 256, 1'b0);

    // Randomized networks, including out-of-range writes.
    for (int it = 0; it < 6; it++) begin
      for (int a = 0; a <= 170; a++) write_w(a, rand_val());
      for (int a = 0; a < 15; a++) write_x(a, rand_val());
      write_w(int'($urandom_range(171, 255)), rand_val());
      write_x(15, rand_val());
      run($sformatf("rand%0d", it), ref_y(), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
